// File: rtl/ccc_dyncfg_pkg.sv
// ccc_dyncfg_pkg: shared types and defaults for the CCC dynamic-config controller.
// Holds the FSM state enum, default parameters and the config word width.
package ccc_dyncfg_pkg;

  localparam int CFG_W            = 81;
  localparam int SCLK_DIV_DEF     = 4;
  localparam int LOCK_FILT_DEF    = 16;
  localparam int LOCK_TIMEOUT_DEF = 65535;
  localparam int MAX_RETRY_DEF    = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    UPDATE,
    WAIT_LOCK,
    RUN,
    FAIL
  } state_e;

endpackage

// File: rtl/ccc_dyncfg_if.sv
// ccc_dyncfg_if: config-word request handshake from the register block.
// Ports: CFG_DATA (word), CFG_VALID (request), CFG_READY (accept).
interface ccc_dyncfg_if
  import ccc_dyncfg_pkg::*;
#(
  parameter int W = CFG_W
);
  logic [W-1:0] CFG_DATA;
  logic         CFG_VALID;
  logic         CFG_READY;

  modport master (
    output CFG_DATA,
    output CFG_VALID,
    input  CFG_READY
  );

  modport slave (
    input  CFG_DATA,
    input  CFG_VALID,
    output CFG_READY
  );
endinterface

// File: rtl/ccc_dyncfg_ctrl_lock.sv
// ccc_lock_filter: 2-flop sync of raw PLL lock plus saturating filter.
// Ports: clk, rst_n, lock_i, clr_i -> locked_o (filtered), lost_o (synced low).
module ccc_lock_filter
  import ccc_dyncfg_pkg::*;
#(
  parameter int LOCK_FILT = LOCK_FILT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lock_i,
  input  logic clr_i,
  output logic locked_o,
  output logic lost_o
);
  localparam int FW = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
  localparam logic [FW-1:0] SAT = FW'(LOCK_FILT - 1);

  logic          s1_q, s2_q;
  logic [FW-1:0] cnt_q, cnt_d;

  // cnt_q counts earlier synced-high cycles, so the current
  // high cycle completes the run when cnt_q hits LOCK_FILT-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !s2_q) cnt_d = '0;
    else if (cnt_q != SAT) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= lock_i;
      s2_q  <= s1_q;
      cnt_q <= cnt_d;
    end
  end

  assign locked_o = s2_q && (cnt_q == SAT);
  assign lost_o   = !s2_q;
endmodule

// File: rtl/ccc_dyncfg_ctrl.sv
// ccc_dyncfg_ctrl: shifts a config word into the CCC, pulses update, waits lock.
// Ports: FAB_CLK, M2F_RESET_N, cfg (slave), PLL_LOCK, ERR_CLR -> CCC port, status.
module ccc_dyncfg_ctrl
  import ccc_dyncfg_pkg::*;
#(
  parameter int SCLK_DIV     = SCLK_DIV_DEF,
  parameter int LOCK_FILT    = LOCK_FILT_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int MAX_RETRY    = MAX_RETRY_DEF
) (
  input  logic        FAB_CLK,
  input  logic        M2F_RESET_N,
  ccc_dyncfg_if.slave cfg,
  input  logic        PLL_LOCK,
  input  logic        ERR_CLR,
  output logic        SDIN,
  output logic        SCLK,
  output logic        SSHIFT,
  output logic        SUPDATE,
  output logic        MODE,
  output logic        DOMAIN_RESET_N,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);
  localparam int PW = $clog2(2 * SCLK_DIV);
  localparam int BW = $clog2(CFG_W);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [PW-1:0] PH_LAST  = PW'(2 * SCLK_DIV - 1);
  localparam logic [PW-1:0] PH_RISE  = PW'(SCLK_DIV);
  localparam logic [PW-1:0] UPD_LAST = PW'(SCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(CFG_W - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(LOCK_TIMEOUT);
  localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRY);

  state_e           state_q, state_d;
  logic [PW-1:0]    ph_q, ph_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic             have_q, have_d;

  logic sdin_q, sclk_q, sshift_q, supdate_q, mode_q, drn_q;
  logic busy_q, done_q, err_q, ready_q;
  logic sdin_d, sclk_d, sshift_d, supdate_d, mode_d, drn_d;
  logic busy_d, done_d, err_d, ready_d;

  logic accept, locked, lost, filt_clr;

  assign accept = ready_q && cfg.CFG_VALID;

  ccc_lock_filter #(
    .LOCK_FILT(LOCK_FILT)
  ) u_lock (
    .clk      (FAB_CLK),
    .rst_n    (M2F_RESET_N),
    .lock_i   (PLL_LOCK),
    .clr_i    (filt_clr),
    .locked_o (locked),
    .lost_o   (lost)
  );

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    bit_d    = bit_q;
    tmo_d    = '0;
    retry_d  = retry_q;
    shadow_d = shadow_q;
    have_d   = have_q;
    unique case (state_q)
      IDLE, FAIL: begin
        if (accept) state_d = LOAD;
      end
      RUN: begin
        if (accept) state_d = LOAD;
        else if (lost) state_d = WAIT_LOCK;
      end
      LOAD: begin
        state_d = SHIFT;
        ph_d    = '0;
        bit_d   = '0;
      end
      SHIFT: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (bit_q == BIT_LAST) state_d = UPDATE;
          else bit_d = bit_q + 1'b1;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      UPDATE: begin
        if (ph_q == UPD_LAST) state_d = WAIT_LOCK;
        else ph_d = ph_q + 1'b1;
      end
      WAIT_LOCK: begin
        tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
        if (locked) begin
          state_d = RUN;
        end else if (tmo_q == TMO_LAST) begin
          // After power-up there is no shadow word to replay.
          if (have_q && retry_q < RTY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = SHIFT;
            ph_d    = '0;
            bit_d   = '0;
          end else begin
            state_d = FAIL;
          end
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
    if (accept) begin
      shadow_d = cfg.CFG_DATA;
      have_d   = 1'b1;
      retry_d  = '0;
    end
  end

  assign filt_clr = (state_d == WAIT_LOCK) && (state_q != WAIT_LOCK);

  // Outputs are decoded from the next state so they line up with it.
  always_comb begin
    sdin_d    = (state_d == SHIFT) && shadow_q[bit_d];
    sclk_d    = (state_d == SHIFT) && (ph_d >= PH_RISE);
    sshift_d  = (state_d == SHIFT);
    supdate_d = (state_d == UPDATE);
    mode_d    = mode_q || (state_d == LOAD);
    drn_d     = (state_d == RUN);
    busy_d    = !(state_d inside {IDLE, RUN, FAIL});
    ready_d   = !busy_d;
    done_d    = (state_q == WAIT_LOCK) && (state_d == RUN);
    err_d     = err_q;
    if (ERR_CLR || state_d == LOAD) err_d = 1'b0;
    if (state_d == FAIL && state_q != FAIL) err_d = 1'b1;
  end

  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      state_q   <= WAIT_LOCK;
      ph_q      <= '0;
      bit_q     <= '0;
      tmo_q     <= '0;
      retry_q   <= '0;
      shadow_q  <= '0;
      have_q    <= 1'b0;
      sdin_q    <= 1'b0;
      sclk_q    <= 1'b0;
      sshift_q  <= 1'b0;
      supdate_q <= 1'b0;
      mode_q    <= 1'b0;
      drn_q     <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      bit_q     <= bit_d;
      tmo_q     <= tmo_d;
      retry_q   <= retry_d;
      shadow_q  <= shadow_d;
      have_q    <= have_d;
      sdin_q    <= sdin_d;
      sclk_q    <= sclk_d;
      sshift_q  <= sshift_d;
      supdate_q <= supdate_d;
      mode_q    <= mode_d;
      drn_q     <= drn_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
    end
  end

  assign SDIN           = sdin_q;
  assign SCLK           = sclk_q;
  assign SSHIFT         = sshift_q;
  assign SUPDATE        = supdate_q;
  assign MODE           = mode_q;
  assign DOMAIN_RESET_N = drn_q;
  assign BUSY           = busy_q;
  assign DONE           = done_q;
  assign ERR            = err_q;
  assign cfg.CFG_READY  = ready_q;
endmodule

// File: tb/tb_ccc_dyncfg_ctrl.sv
// tb_ccc_dyncfg_ctrl: directed bench for the CCC dynamic-config controller.
// Short lock timeout keeps the retry scenario within a few thousand cycles.
module tb_ccc_dyncfg_ctrl;
  localparam int W   = ccc_dyncfg_pkg::CFG_W;
  localparam int TMO = 200;
  localparam logic [9:0] RST_V = 10'b0000001000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll = 1'b0;
  logic err_clr = 1'b0;
  logic sdin, sclk, sshift, supdate, mode, drn, busy, done, err;

  int n_vec = 0;
  int n_bad = 0;
  int ndone = 0;

  logic [W-1:0] data, got;
  int t, nrise, nss, nupd, gap_bad, mode_bad, last_rise;
  logic prev_sclk, prev_ss;

  ccc_dyncfg_if #(.W(W)) cfg_if ();

  ccc_dyncfg_ctrl #(
    .SCLK_DIV     (4),
    .LOCK_FILT    (16),
    .LOCK_TIMEOUT (TMO),
    .MAX_RETRY    (3)
  ) dut (
    .FAB_CLK        (clk),
    .M2F_RESET_N    (rst_n),
    .cfg            (cfg_if),
    .PLL_LOCK       (pll),
    .ERR_CLR        (err_clr),
    .SDIN           (sdin),
    .SCLK           (sclk),
    .SSHIFT         (sshift),
    .SUPDATE        (supdate),
    .MODE           (mode),
    .DOMAIN_RESET_N (drn),
    .BUSY           (busy),
    .DONE           (done),
    .ERR            (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got_v,
                     input logic [127:0] exp_v);
    n_vec++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step(1);
      if (done) ndone++;
    end
  endtask

  function automatic logic [9:0] outs();
    return {sdin, sclk, sshift, supdate, mode,
            drn, busy, done, err, cfg_if.CFG_READY};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_if.CFG_DATA  = '0;
    cfg_if.CFG_VALID = 1'b0;
    pll = 1'b1;
    #12;
    chk("reset_outs", outs(), RST_V);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    step(17);
    chk("pre_lock_drn", drn, 1'b0);
    step(1);
    chk("lock_drn", drn, 1'b1);
    chk("lock_done", done, 1'b1);
    step(1);
    chk("done_1cyc", done, 1'b0);
    chk("run_ready", cfg_if.CFG_READY, 1'b1);
    chk("run_busy", busy, 1'b0);

    data = 81'h1_5555_5555_5555_5555_5555;
    cfg_if.CFG_DATA  = data;
    cfg_if.CFG_VALID = 1'b1;
    step(1);
    cfg_if.CFG_VALID = 1'b0;
    cfg_if.CFG_DATA  = '0;
    pll = 1'b0;
    chk("load_mode", mode, 1'b1);
    chk("load_ready", cfg_if.CFG_READY, 1'b0);
    chk("load_drn", drn, 1'b0);
    chk("load_sshift", sshift, 1'b0);
    step(1);
    chk("shift_start", {sshift, sdin}, {1'b1, data[0]});

    t = 1; nrise = 0; nss = 1; nupd = 0;
    gap_bad = 0; mode_bad = 0; last_rise = 0; got = '0;
    prev_sclk = sclk; prev_ss = sshift;
    while (!err && t < 5000) begin
      step(1);
      t++;
      if (sclk && !prev_sclk) begin
        if (nrise < W) got[nrise] = sdin;
        if (nrise % W != 0 && t - last_rise != 8) gap_bad++;
        last_rise = t;
        nrise++;
      end
      if (sshift && !prev_ss) nss++;
      if (supdate) nupd++;
      if (!mode) mode_bad++;
      prev_sclk = sclk;
      prev_ss   = sshift;
    end
    chk("sclk_pulses", nrise, 4 * 81);
    chk("sdin_word", got, data);
    chk("sclk_gap", gap_bad, 0);
    chk("supdate_cyc", nupd, 4 * 4);
    chk("shift_count", nss, 4);
    chk("mode_held", mode_bad, 0);
    chk("fail_cycle", t, 3409);
    chk("fail_drn", drn, 1'b0);
    chk("fail_ready", cfg_if.CFG_READY, 1'b1);
    chk("fail_busy", busy, 1'b0);

    pll = 1'b1;
    cfg_if.CFG_DATA  = 81'h0_0000_0000_0000_0000_00a5;
    cfg_if.CFG_VALID = 1'b1;
    step(1);
    cfg_if.CFG_VALID = 1'b0;
    chk("reload_err", err, 1'b0);
    chk("reload_busy", busy, 1'b1);
    t = 0;
    while (!done && t < 1000) begin
      step(1);
      t++;
    end
    chk("relock_cycle", t, 669);
    chk("relock_drn", drn, 1'b1);

    step(1);
    pll = 1'b0;
    step(1);
    pll = 1'b1;
    step(1);
    chk("loss_drn_p2", drn, 1'b1);
    step(1);
    chk("loss_drn_p3", drn, 1'b0);
    chk("loss_busy", busy, 1'b1);
    step(15);
    chk("loss_relock_pre", drn, 1'b0);
    step(1);
    chk("loss_relock", {drn, done}, 2'b11);

    step(1);
    pll = 1'b0;
    step(3);
    chk("glitch_wait", drn, 1'b0);
    step(2);
    ndone = 0;
    pll = 1'b1;
    run(15);
    pll = 1'b0;
    run(1);
    pll = 1'b1;
    run(17);
    chk("glitch_nolock", ndone, 0);
    chk("glitch_drn", drn, 1'b0);
    step(1);
    chk("glitch_lock", {drn, done}, 2'b11);

    step(1);
    cfg_if.CFG_DATA  = 81'h1_2345_6789_abcd_ef01_2345;
    cfg_if.CFG_VALID = 1'b1;
    step(1);
    cfg_if.CFG_VALID = 1'b0;
    step(323);
    chk("mid_shift", {sshift, mode}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("async_reset", outs(), RST_V);
    pll = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("post_rst_mode", {mode, busy, cfg_if.CFG_READY}, 3'b010);

    t = 0; nss = 0; prev_ss = sshift;
    while (!err && t < 1000) begin
      step(1);
      t++;
      if (sshift && !prev_ss) nss++;
      prev_ss = sshift;
    end
    chk("por_fail_cycle", t, TMO);
    chk("por_no_shift", nss, 0);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("err_clr", {err, cfg_if.CFG_READY}, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
